eth_pcs_rx_block_lock_mc: RTL and testbench
===========================================

// Module: eth_pcs_rx_block_lock_mc
// PURPOSE
//  Multi-lane 66b block-lock synchroniser for the RX PCS (clause-49 lock FSM), one independent FSM per lane.
//  Sits between the RX gearbox and the descrambler/decoder.
//  Tests the sync header of every received block, drives a slip request back to the gearbox and reports block lock per lane.
//  Generalises single-lane block sync to N lanes with configurable thresholds, slip settle time and an optional hi-BER monitor.
// PARAMETERS
//  N_LANES      4      independent lanes
//  SH_TH        64     headers per test window
//  SH_INVAL_TH  16     invalid headers per window that drop lock
//  SLIP_WAIT    2      cycles headers are ignored after a slip (gearbox settle)
//  BER_WIN      19531  valid-header window of the hi-BER monitor (125us at 156.25MHz)
//  BER_TH       16     invalid headers per BER window that assert hi_ber
// PORTS
//  i_clk          in   1               PCS RX clock
//  i_rst_n        in   1               asynchronous reset, active low
//  i_hdr_valid    in   N_LANES         lane n: i_sync slice carries a new header
//  i_sync         in   N_LANES*W_SYNC  lane n header at [n*W_SYNC +: W_SYNC]
//  o_slip         out  N_LANES         1-cycle pulse: gearbox shifts alignment by one bit
//  o_block_lock   out  N_LANES         lane locked
//  o_hi_ber       out  N_LANES         lane high bit-error rate (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, all FSMs in LOCK_INIT, all counters 0. Reset is async and may assert at any point; recovery restarts from LOCK_INIT.
//  - A header is valid iff it equals SYNC_DATA or SYNC_CTRL; 2'b00 and 2'b11 are invalid.
//  - FSM states per lane:
//    - LOCK_INIT: lock=0. Next state RESET_CNT.
//    - RESET_CNT: sh_cnt=0, inv_cnt=0. Next state TEST_SH.
//    - TEST_SH: waits for i_hdr_valid. Each header increments sh_cnt; an invalid header also increments inv_cnt.
//  - Decision on the cycle a header is sampled, in priority order:
//    1. Invalid and (inv_cnt+1==SH_INVAL_TH or !lock) -> SLIP.
//    2. sh_cnt+1==SH_TH and inv_cnt(updated)==0 -> lock=1, counters cleared, stay in TEST_SH.
//    3. sh_cnt+1==SH_TH, some invalid -> counters cleared, lock unchanged.
//    4. Otherwise remain in TEST_SH.
//  - Latency: o_block_lock rises on the clock edge that samples the SH_TH-th clean header, i.e. visible the following cycle.
//  - SLIP:
//    - lock=0; o_slip high for exactly 1 cycle, the cycle after the triggering header.
//    - Then SLIP_WAIT cycles during which i_hdr_valid is ignored, then RESET_CNT.
//  - Counter widths: $clog2(SH_TH+1) and $clog2(SH_INVAL_TH+1). No wrap is possible because windows close at the threshold.
//  - Lanes share no state; simultaneous events on different lanes are independent.
//  - i_hdr_valid low: no counter change, no state change, except the SLIP_WAIT countdown.
// CONFIGURATION
//  Macro ETH_PCS_HI_BER_EN.
//  Defined: per-lane hi-BER monitor, active only while o_block_lock=1.
//   - Counts valid-strobed headers to BER_WIN and invalid headers, saturating at BER_TH.
//   - o_hi_ber set the cycle after the BER_TH-th invalid header in the window.
//   - At window end: o_hi_ber cleared if count<BER_TH; both counters restart.
//   - Lock loss clears the counters and o_hi_ber.
//  Not defined: monitor logic absent; o_hi_ber tied to 0.
// STRUCTURE
//  eth_pcs_params gains:
//   - typedef enum blk_lock_state_t {LOCK_INIT, RESET_CNT, TEST_SH, SLIP}
//   - SLIP_WAIT_DEF, BER_WIN_DEF, BER_TH_DEF
//   - function is_valid_sh(sync)
//  Sub-module eth_pcs_block_lock_lane: one-lane FSM plus optional BER monitor, instantiated N_LANES times by generate.
//  The top level only slices the buses.
// TESTING
//  Run with SLIP_WAIT=2 unless stated.
//  1. Lane0, 64 headers 2'b01 with valid every cycle -> o_block_lock[0]=1 the cycle after the 64th; o_slip[0] never asserted.
//  2. Unlocked lane0, header 10 = 2'b00 -> o_slip[0] pulses 1 cycle next cycle; next 2 valids ignored; then 64 clean headers -> lock.
//  3. Locked lane0:
//     - 15 invalid headers in one 64-window -> lock stays 1, counters clear at the 64th.
//     - 16 invalid -> lock=0 and o_slip pulse on the cycle after the 16th.
//  4. Lane0 clean, lane1 all 2'b11, lane2 valid strobe low -> lane0 locks at 64; lane1 slips every 3 cycles; lane2 holds in TEST_SH with lock=0.
//  5. Assert i_rst_n mid-SLIP_WAIT and while locked -> all outputs 0 asynchronously; relock needs a full 64 clean headers.
//  6. ETH_PCS_HI_BER_EN, BER_WIN=128, BER_TH=16:
//     - Locked, 8 invalid per 64 headers -> o_hi_ber=1 after the 16th invalid.
//     - Next 128 headers clean -> cleared at window end.
//     - Same stimulus without the macro -> o_hi_ber=0.

Source files
------------

// File: rtl/eth_pcs_params.sv
// Shared constants, lock-FSM state encoding and sync-header helper for the RX PCS block-lock logic.
// The hi-BER defaults exist only when ETH_PCS_HI_BER_EN is defined.
package eth_pcs_params;

  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  localparam int N_LANES_DEF     = 4;
  localparam int SH_TH_DEF       = 64;
  localparam int SH_INVAL_TH_DEF = 16;
  localparam int SLIP_WAIT_DEF   = 2;
`ifdef ETH_PCS_HI_BER_EN
  localparam int BER_WIN_DEF     = 19531;
  localparam int BER_TH_DEF      = 16;
`endif

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    RESET_CNT = 2'd1,
    TEST_SH   = 2'd2,
    SLIP      = 2'd3
  } blk_lock_state_t;

  // Plain-vector aliases of the state encoding for legacy FSM code.
  localparam logic [1:0] ST_LOCK_INIT = 2'd0;
  localparam logic [1:0] ST_RESET_CNT = 2'd1;
  localparam logic [1:0] ST_TEST_SH   = 2'd2;
  localparam logic [1:0] ST_SLIP      = 2'd3;

  function automatic logic is_valid_sh(input logic [W_SYNC-1:0] sync);
    return (sync == SYNC_DATA) || (sync == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_block_lock_lane.sv
// One lane of 66b block lock: header-test FSM, slip request and, with ETH_PCS_HI_BER_EN,
// a hi-BER monitor that runs only while the lane is locked.
module eth_pcs_block_lock_lane
  import eth_pcs_params::*;
#(
  parameter int SH_TH       = SH_TH_DEF,
  parameter int SH_INVAL_TH = SH_INVAL_TH_DEF,
  parameter int SLIP_WAIT   = SLIP_WAIT_DEF
`ifdef ETH_PCS_HI_BER_EN
  ,
  parameter int BER_WIN     = BER_WIN_DEF,
  parameter int BER_TH      = BER_TH_DEF
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hdr_valid,
  input  logic [W_SYNC-1:0] i_sync,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_hi_ber
);

  localparam int SH_W   = $clog2(SH_TH + 1);
  localparam int INV_W  = $clog2(SH_INVAL_TH + 1);
  localparam int WAIT_N = (SLIP_WAIT < 1) ? 1 : SLIP_WAIT;
  localparam int WAIT_W = $clog2(WAIT_N + 1);

  logic [1:0]        state, state_nxt;
  logic [SH_W-1:0]   sh_cnt, sh_cnt_nxt;
  logic [INV_W-1:0]  inv_cnt, inv_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              lock, lock_nxt;
  logic              slip, slip_nxt;
  logic              sh_bad;

  assign sh_bad = !is_valid_sh(i_sync);

  // The SLIP state covers the pulse cycle plus the rest of the settle time and clears the
  // counters on entry, so a permanently bad lane retries every WAIT_N+1 cycles.
  always_comb begin
    state_nxt    = state;
    sh_cnt_nxt   = sh_cnt;
    inv_cnt_nxt  = inv_cnt;
    wait_cnt_nxt = wait_cnt;
    lock_nxt     = lock;
    slip_nxt     = 1'b0;
    case (state)
      ST_LOCK_INIT: begin
        lock_nxt  = 1'b0;
        state_nxt = ST_RESET_CNT;
      end
      ST_RESET_CNT: begin
        sh_cnt_nxt  = '0;
        inv_cnt_nxt = '0;
        state_nxt   = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (i_hdr_valid) begin
          if (sh_bad && ((inv_cnt == INV_W'(SH_INVAL_TH - 1)) || !lock)) begin
            state_nxt    = ST_SLIP;
            lock_nxt     = 1'b0;
            slip_nxt     = 1'b1;
            wait_cnt_nxt = WAIT_W'(WAIT_N - 1);
            sh_cnt_nxt   = '0;
            inv_cnt_nxt  = '0;
          end else if (sh_cnt == SH_W'(SH_TH - 1)) begin
            if ((inv_cnt == '0) && !sh_bad) lock_nxt = 1'b1;
            sh_cnt_nxt  = '0;
            inv_cnt_nxt = '0;
          end else begin
            sh_cnt_nxt = sh_cnt + 1'b1;
            if (sh_bad) inv_cnt_nxt = inv_cnt + 1'b1;
          end
        end
      end
      ST_SLIP: begin
        if (wait_cnt == '0) state_nxt = ST_TEST_SH;
        else wait_cnt_nxt = wait_cnt - 1'b1;
      end
      default: state_nxt = ST_LOCK_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_LOCK_INIT;
      sh_cnt   <= '0;
      inv_cnt  <= '0;
      wait_cnt <= '0;
      lock     <= 1'b0;
      slip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh_cnt   <= sh_cnt_nxt;
      inv_cnt  <= inv_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      lock     <= lock_nxt;
      slip     <= slip_nxt;
    end
  end

  assign o_slip       = slip;
  assign o_block_lock = lock;

`ifdef ETH_PCS_HI_BER_EN
  localparam int BW_W = $clog2(BER_WIN + 1);
  localparam int BT_W = $clog2(BER_TH + 1);

  logic [BW_W-1:0] ber_cnt;
  logic [BT_W-1:0] bad_cnt;
  logic            hi_ber;
  logic            bad_sat, bad_hit;

  assign bad_sat = (bad_cnt == BT_W'(BER_TH));
  assign bad_hit = sh_bad && !bad_sat && (bad_cnt == BT_W'(BER_TH - 1));

  // Clearing on lock_nxt lets hi_ber drop on the same edge that drops lock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ber_cnt <= '0;
      bad_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (!lock_nxt) begin
      ber_cnt <= '0;
      bad_cnt <= '0;
      hi_ber  <= 1'b0;
    end else if (lock && i_hdr_valid) begin
      if (ber_cnt == BW_W'(BER_WIN - 1)) begin
        ber_cnt <= '0;
        bad_cnt <= '0;
        hi_ber  <= bad_sat || bad_hit;
      end else begin
        ber_cnt <= ber_cnt + 1'b1;
        if (sh_bad && !bad_sat) bad_cnt <= bad_cnt + 1'b1;
        if (bad_hit) hi_ber <= 1'b1;
      end
    end
  end

  assign o_hi_ber = hi_ber;
`else
  assign o_hi_ber = 1'b0;
`endif

endmodule

// File: rtl/eth_pcs_rx_block_lock_mc.sv
// Multi-lane 66b block-lock synchroniser: one independent eth_pcs_block_lock_lane per lane.
// Optional hi-BER monitor enabled by defining ETH_PCS_HI_BER_EN.
module eth_pcs_rx_block_lock_mc
  import eth_pcs_params::*;
#(
  parameter int N_LANES     = N_LANES_DEF,
  parameter int SH_TH       = SH_TH_DEF,
  parameter int SH_INVAL_TH = SH_INVAL_TH_DEF,
  parameter int SLIP_WAIT   = SLIP_WAIT_DEF
`ifdef ETH_PCS_HI_BER_EN
  ,
  parameter int BER_WIN     = BER_WIN_DEF,
  parameter int BER_TH      = BER_TH_DEF
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_LANES-1:0]        i_hdr_valid,
  input  logic [N_LANES*W_SYNC-1:0] i_sync,
  output logic [N_LANES-1:0]        o_slip,
  output logic [N_LANES-1:0]        o_block_lock,
  output logic [N_LANES-1:0]        o_hi_ber
);

  for (genvar n = 0; n < N_LANES; n++) begin : g_lane
    eth_pcs_block_lock_lane #(
      .SH_TH       (SH_TH),
      .SH_INVAL_TH (SH_INVAL_TH),
      .SLIP_WAIT   (SLIP_WAIT)
`ifdef ETH_PCS_HI_BER_EN
      ,
      .BER_WIN     (BER_WIN),
      .BER_TH      (BER_TH)
`endif
    ) u_lane (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_hdr_valid  (i_hdr_valid[n]),
      .i_sync       (i_sync[n*W_SYNC +: W_SYNC]),
      .o_slip       (o_slip[n]),
      .o_block_lock (o_block_lock[n]),
      .o_hi_ber     (o_hi_ber[n])
    );
  end

endmodule

// File: tb/tb_eth_pcs_rx_block_lock_mc.sv
// Directed table-driven bench for eth_pcs_rx_block_lock_mc (4 lanes, SH_TH=64, SH_INVAL_TH=16,
// SLIP_WAIT=2); hi-BER expectations follow ETH_PCS_HI_BER_EN with BER_WIN=128, BER_TH=16.
module tb_eth_pcs_rx_block_lock_mc;

`ifdef ETH_PCS_HI_BER_EN
  localparam logic HB = 1'b1;
`else
  localparam logic HB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hdr_valid = 4'b0000;
  logic [7:0] sync_bus = 8'h55;
  logic [3:0] slip;
  logic [3:0] block_lock;
  logic [3:0] hi_ber;

  always #5 clk = ~clk;

  eth_pcs_rx_block_lock_mc #(
    .N_LANES     (4),
    .SH_TH       (64),
    .SH_INVAL_TH (16),
    .SLIP_WAIT   (2)
`ifdef ETH_PCS_HI_BER_EN
    ,
    .BER_WIN     (128),
    .BER_TH      (16)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hdr_valid  (hdr_valid),
    .i_sync       (sync_bus),
    .o_slip       (slip),
    .o_block_lock (block_lock),
    .o_hi_ber     (hi_ber)
  );

  // One record drives the same inputs for reps cycles, then checks the outputs
  // after the last edge plus the OR of o_slip seen over the whole stretch.
  typedef struct {
    logic [3:0] valid;
    logic [7:0] sync;
    int         reps;
    logic [3:0] exp_slip;
    logic [3:0] exp_lock;
    logic [3:0] exp_hi;
    logic [3:0] exp_seen;
  } vec_t;

  vec_t vecs[24];
  int   n_vec = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input int idx, input logic [3:0] act,
                             input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] v, input logic [7:0] s, input int r,
                        input logic [3:0] es, input logic [3:0] el,
                        input logic [3:0] eh, input logic [3:0] en);
    vecs[n_vec] = '{valid: v, sync: s, reps: r, exp_slip: es, exp_lock: el,
                    exp_hi: eh, exp_seen: en};
    n_vec++;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [3:0] seen;
    seen = 4'b0000;
    for (int r = 0; r < v.reps; r++) begin
      hdr_valid = v.valid;
      sync_bus  = v.sync;
      @(posedge clk);
      #1;
      seen = seen | slip;
    end
    hdr_valid = 4'b0000;
    sync_bus  = 8'h55;
    checkOutput("slip", idx, slip, v.exp_slip);
    checkOutput("block_lock", idx, block_lock, v.exp_lock);
    checkOutput("hi_ber", idx, hi_ber, v.exp_hi);
    checkOutput("slip_seen", idx, seen, v.exp_seen);
  endtask

  task automatic idle(input int n);
    hdr_valid = 4'b0000;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input int idx);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_slip", idx, slip, 4'b0000);
    checkOutput("rst_lock", idx, block_lock, 4'b0000);
    checkOutput("rst_hi_ber", idx, hi_ber, 4'b0000);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
  endtask

  vec_t hv;

  initial begin
    #2;
    checkOutput("init_slip", 0, slip, 4'b0000);
    checkOutput("init_lock", 0, block_lock, 4'b0000);
    checkOutput("init_hi_ber", 0, hi_ber, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Lane 0: lock, hi-BER window, invalid thresholds while locked, slip while unlocked.
    n_vec = 0;
    addVec(4'b0001, 8'h55, 63,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 1,   4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 8,   4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 56,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 7,   4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 1,   4'b0000, 4'b0001, {3'b000, HB}, 4'b0000);
    addVec(4'b0001, 8'h55, 56,  4'b0000, 4'b0001, {3'b000, HB}, 4'b0000);
    addVec(4'b0001, 8'h55, 127, 4'b0000, 4'b0001, {3'b000, HB}, 4'b0000);
    addVec(4'b0001, 8'h55, 1,   4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 15,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 49,  4'b0000, 4'b0001, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 15,  4'b0000, 4'b0001, {3'b000, HB}, 4'b0000);
    addVec(4'b0001, 8'h54, 1,   4'b0001, 4'b0000, 4'b0000, 4'b0001);
    addVec(4'b0001, 8'h55, 2,   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 9,   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h54, 1,   4'b0001, 4'b0000, 4'b0000, 4'b0001);
    addVec(4'b0001, 8'h55, 2,   4'b0000, 4'b0000, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 63,  4'b0000, 4'b0000, 4'b0000, 4'b0000);
    addVec(4'b0001, 8'h55, 1,   4'b0000, 4'b0001, 4'b0000, 4'b0000);
    for (int i = 0; i < n_vec; i++) applyStimulus(vecs[i], 100 + i);

    // Asynchronous reset while lane 0 is locked.
    pulseReset(200);

    // Lane 0 clean, lane 1 all 2'b11, lane 2 strobe low, then lane 2 alone.
    n_vec = 0;
    addVec(4'b0011, 8'h5D, 63, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    addVec(4'b0011, 8'h5D, 1,  4'b0010, 4'b0001, 4'b0000, 4'b0010);
    addVec(4'b0100, 8'h55, 64, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    for (int i = 0; i < n_vec; i++) applyStimulus(vecs[i], 300 + i);

    // Reset asserted while lane 3 sits in its slip settle time; relock needs 64 full headers.
    hv = '{valid: 4'b1000, sync: 8'h15, reps: 1, exp_slip: 4'b1000, exp_lock: 4'b0101,
           exp_hi: 4'b0000, exp_seen: 4'b1000};
    applyStimulus(hv, 400);
    pulseReset(401);
    hv = '{valid: 4'b1001, sync: 8'h55, reps: 63, exp_slip: 4'b0000, exp_lock: 4'b0000,
           exp_hi: 4'b0000, exp_seen: 4'b0000};
    applyStimulus(hv, 402);
    hv = '{valid: 4'b1001, sync: 8'h55, reps: 1, exp_slip: 4'b0000, exp_lock: 4'b1001,
           exp_hi: 4'b0000, exp_seen: 4'b0000};
    applyStimulus(hv, 403);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
